delay_line_seq: RTL and testbench
=================================

Name: delay_line_seq

Overview:
- Sequencer for the per-row delayLine bank feeding the conv window builder.
- Accepts a per-layer config, derives delay_depth, resets the delay lines, and gates their enable from a valid/ready input stream.
- Suppresses outputs while the lines prime, then flushes them with zero beats at frame end.
- Sits between the activation stream source and the window/MAC stage; delay-line data does not pass through this block.

Parameters:
- MAX_DEPTH, 128, largest delay_depth the delay lines support.
- CNT_W, 16, width of frame/fill beat counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config accepted when cfg_valid&cfg_ready
- cfg_cin  in  12  input channels of layer
- cfg_fill_len  in  CNT_W  beats to prime delay chain before outputs are valid
- cfg_frame_len  in  CNT_W  input beats per frame
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted
- m_valid  out  1  delay-line output beat valid (aligned with delayLine dout)
- m_ready  in  1  downstream accepts
- dl_en  out  1  enable to all delay lines
- dl_rst  out  1  synchronous reset to delay lines
- dl_depth  out  8  delay_depth to delay lines
- dl_flush  out  1  selects zero onto delay-line din
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after last output beat
- err_cfg  out  1  sticky, set on rejected config, cleared by next accepted config

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except dl_rst=1. Counters cleared; dl_depth=0.
- Depth: dl_depth = ceil(cfg_cin/8) = (cin>>3) + (cin[2:0]!=0), computed in 13 bits.
- Config rejection: config is rejected if depth==0, depth>MAX_DEPTH, cfg_frame_len==0, or cfg_fill_len>=cfg_frame_len. On rejection: err_cfg<=1, stay IDLE, dl_depth unchanged.
- States:
  - IDLE: cfg_ready=1. On a valid config: latch fields, dl_depth<=depth, err_cfg<=0, go to CLR.
  - CLR: exactly one cycle, dl_rst=1. Next state is FILL, or RUN if fill_len==0.
  - FILL / RUN / DRAIN share the skid rule below.
  - FILL: count accepted beats. When the fill_len-th beat is accepted, go to RUN. No m_valid is raised for fill beats.
  - RUN: each accepted beat sets m_valid next cycle. When beat frame_len is accepted, go to DRAIN, or DONE if fill_len==0.
  - DRAIN: s_ready=0, dl_flush=1, dl_en=(!m_valid|m_ready). Each enabled cycle is one flush beat producing m_valid next cycle. After fill_len flush beats, go to DONE.
  - DONE: wait until the final m_valid beat is taken, then pulse frame_done and go to IDLE.
- Skid rule (FILL/RUN/DRAIN):
  - s_ready = !m_valid | m_ready.
  - dl_en = s_valid & s_ready in FILL/RUN; the DRAIN rule above applies in DRAIN.
  - m_valid holds while m_valid & !m_ready.
  - dl_en is never asserted while m_valid & !m_ready, so delayLine dout holds.
- Latency: input beat k (0-based, k>=fill_len) appears as m beat k-fill_len. Flush beats yield the last fill_len outputs. Total m beats = frame_len exactly.
- Boundaries:
  - cfg_valid outside IDLE: ignored (cfg_ready=0).
  - Reset mid-frame: immediate return to IDLE with dl_rst=1. No frame_done.
  - m_ready low for N cycles: no dl_en for N cycles; no beats lost or duplicated.
  - Counters never wrap: frame_len < 2^CNT_W.

Test Plan:
- Config cin=64, fill=4, frame=10, s_valid and m_ready held 1 -> dl_depth=8; dl_rst high for one cycle; first m_valid on the cycle after input beat 4 is accepted; 4 flush cycles with dl_flush=1; exactly 10 m beats; frame_done pulses once.
- cin=20 -> dl_depth=3. cin=0 -> err_cfg=1, stays IDLE. cin=1032 -> depth 129 > MAX_DEPTH -> err_cfg=1. A following valid config clears err_cfg.
- fill=0, frame=5 -> FILL skipped; m_valid one cycle after each accept; no DRAIN cycles; 5 m beats.
- RUN with m_ready toggling 1,0,0,1 -> s_ready and dl_en low during the stall; m_valid held; output beat order matches input beats with no gaps or duplicates.
- Assert rst_n=0 during DRAIN -> all outputs immediately 0 except dl_rst=1; busy=0 after release; the next config starts cleanly.
- cfg_valid pulsed during RUN -> cfg_ready=0; latched fields and dl_depth unchanged.

Source files
------------

// File: rtl/delay_line_seq.sv
// delay_line_seq: sequences the per-row delay-line bank (config, clear, prime, run, flush)
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready        layer config handshake; cfg_cin, cfg_fill_len, cfg_frame_len
//   s_valid/s_ready            input activation beat handshake
//   m_valid/m_ready            delay-line output beat handshake (aligned with delay-line dout)
//   dl_en, dl_rst, dl_depth    delay-line enable, synchronous clear, depth
//   dl_flush                   selects zero onto delay-line din while draining
//   busy, frame_done, err_cfg  status: not idle, end-of-frame pulse, sticky config error
module delay_line_seq #(
   parameter int MAX_DEPTH = 128,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [11:0]      cfg_cin,
   input  logic [CNT_W-1:0] cfg_fill_len,
   input  logic [CNT_W-1:0] cfg_frame_len,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             dl_en,
   output logic             dl_rst,
   output logic [7:0]       dl_depth,
   output logic             dl_flush,
   output logic             busy,
   output logic             frame_done,
   output logic             err_cfg
);
   typedef enum logic [2:0] {IDLE, CLR, FILL, RUN, DRAIN, DONE} state_t;
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc, fill_q, frame_q;
   logic [12:0]      depth;
   logic             boot, cfg_bad, cfg_ok, m_valid_nx, done_nx;
   // boot holds the delay lines in reset and blocks config for the first cycle after rst_n release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         boot       <= 1'b1;
         cnt        <= '0;
         fill_q     <= '0;
         frame_q    <= '0;
         m_valid    <= 1'b0;
         frame_done <= 1'b0;
         dl_depth   <= '0;
         err_cfg    <= 1'b0;
      end else begin
         state      <= state_nx;
         boot       <= 1'b0;
         cnt        <= cnt_nx;
         m_valid    <= m_valid_nx;
         frame_done <= done_nx;
         if (cfg_ok) begin
            fill_q   <= cfg_fill_len;
            frame_q  <= cfg_frame_len;
            dl_depth <= depth[7:0];
         end
         if (cfg_valid & cfg_ready) err_cfg <= cfg_bad;
      end
   end
   // cnt counts accepted input beats across FILL and RUN, then restarts for flush beats in DRAIN
   always_comb begin
      depth      = {4'd0, cfg_cin[11:3]} + {12'd0, |cfg_cin[2:0]};
      cfg_bad    = (depth == 13'd0) | (depth > 13'(MAX_DEPTH)) | (cfg_frame_len == '0) |
                   (cfg_fill_len >= cfg_frame_len);
      cfg_ok     = cfg_valid & cfg_ready & !cfg_bad;
      cnt_inc    = cnt + CNT_W'(1);
      m_valid_nx = (dl_en & (state != FILL)) | (m_valid & !m_ready);
      done_nx    = (state == DONE) & (!m_valid | m_ready);
      state_nx   = state;
      cnt_nx     = cnt;
      unique case (state)
         IDLE: begin
            state_nx = cfg_ok ? CLR : IDLE;
            cnt_nx   = cfg_ok ? '0 : cnt;
         end
         CLR: state_nx = (fill_q == '0) ? RUN : FILL;
         FILL: if (dl_en) begin
            cnt_nx   = cnt_inc;
            state_nx = (cnt_inc == fill_q) ? RUN : FILL;
         end
         RUN: if (dl_en) begin
            cnt_nx   = (cnt_inc == frame_q) ? '0 : cnt_inc;
            state_nx = (cnt_inc != frame_q) ? RUN : (fill_q == '0) ? DONE : DRAIN;
         end
         DRAIN: if (dl_en) begin
            cnt_nx   = cnt_inc;
            state_nx = (cnt_inc == fill_q) ? DONE : DRAIN;
         end
         DONE: state_nx = done_nx ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   // a stalled output beat (m_valid & !m_ready) blocks both intake and enable so dout holds
   always_comb begin
      cfg_ready = (state == IDLE) & !boot;
      s_ready   = ((state == FILL) | (state == RUN)) & (!m_valid | m_ready);
      dl_en     = (state == DRAIN) ? (!m_valid | m_ready) : (s_valid & s_ready);
      dl_rst    = boot | (state == CLR);
      dl_flush  = state == DRAIN;
      busy      = state != IDLE;
   end
endmodule

// File: tb/tb_delay_line_seq.sv
// tb_delay_line_seq: table-driven and randomized checks of delay_line_seq against a delay-line beat model
module tb_delay_line_seq;
   localparam int CNT_W = 16;
   typedef struct {
      int cin;
      int fill;
      int frame;
      bit ok;
      int depth;
   } vec_t;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [11:0]      cfg_cin = '0;
   logic [CNT_W-1:0] cfg_fill_len = '0;
   logic [CNT_W-1:0] cfg_frame_len = '0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic             m_valid;
   logic             m_ready = 1'b1;
   logic             dl_en, dl_rst, dl_flush, busy, frame_done, err_cfg;
   logic [7:0]       dl_depth;
   int tests = 0, fails = 0;
   // beat model: each delay-line enable pushes a label (input index, or -1 for a flush zero);
   // once fill_m labels are queued, an enable presents the label fill_m enables older on the output
   int hist[$];
   int got[$];
   int en_n = 0, in_n = 0, fill_m = 0, out_lbl = 0, viol = 0;
   int rst_cnt = 0, flush_n = 0, done_n = 0, cyc = 0, first_mv = -1, done_cyc = -1;
   bit have_out = 1'b0;
   int exp_depth = 0;
   vec_t vt[11];

   always #5 clk = ~clk;

   delay_line_seq #(.MAX_DEPTH(128), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cin(cfg_cin),
      .cfg_fill_len(cfg_fill_len), .cfg_frame_len(cfg_frame_len),
      .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
      .dl_en(dl_en), .dl_rst(dl_rst), .dl_depth(dl_depth), .dl_flush(dl_flush),
      .busy(busy), .frame_done(frame_done), .err_cfg(err_cfg)
   );

   always @(negedge clk) begin
      if (!rst_n) have_out = 1'b0;
      else begin
         if (cfg_valid && cfg_ready) begin
            cyc = 0; fill_m = int'(cfg_fill_len);
            hist.delete(); got.delete();
            en_n = 0; in_n = 0; have_out = 1'b0; rst_cnt = 0; flush_n = 0; done_n = 0;
            first_mv = -1; done_cyc = -1;
         end else cyc++;
         if (dl_rst) rst_cnt++;
         if (frame_done) begin done_n++; done_cyc = cyc; end
         if (m_valid && first_mv < 0) first_mv = cyc;
         if (m_valid != have_out) viol++;
         if (m_valid && !m_ready && (dl_en || s_ready)) viol++;
         if (dl_flush && s_ready) viol++;
         if ((s_valid && s_ready) != (dl_en && !dl_flush)) viol++;
         if (m_valid && m_ready) begin got.push_back(out_lbl); have_out = 1'b0; end
         if (dl_en) begin
            hist.push_back(dl_flush ? -1 : in_n);
            if (dl_flush) flush_n++; else in_n++;
            if (en_n >= fill_m) begin out_lbl = hist[en_n - fill_m]; have_out = 1'b1; end
            en_n++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_outputs", int'({cfg_ready, s_ready, m_valid, dl_en, dl_rst, dl_flush, busy, frame_done, err_cfg}), 16);
      chk("rst_depth", int'(dl_depth), 0);
   endtask

   task automatic apply_cfg(input int cin, input int fill, input int frame, input bit ok, input int depth);
      @(posedge clk); #1;
      chk("cfg_ready_idle", int'(cfg_ready), 1);
      cfg_valid = 1'b1; cfg_cin = 12'(cin); cfg_fill_len = CNT_W'(fill); cfg_frame_len = CNT_W'(frame);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      chk("busy_after_cfg", int'(busy), int'(ok));
      chk("err_cfg", int'(err_cfg), int'(!ok));
      chk("dl_depth", int'(dl_depth), depth);
   endtask

   // mode 0: s_valid/m_ready held 1; mode 1: random; mode 2: m_ready cycles 1,0,0,1
   task automatic run_frame(input int frame, input int fill, input int mode, input bit poke);
      int k = 0;
      int v0 = viol;
      int pv = 0;
      int e = 0;
      int d0 = exp_depth;
      logic [3:0] pat = 4'b1001;
      while (done_n == 0 && k < 4000) begin
         s_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         m_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : (mode == 2) ? pat[k % 4] : 1'b1;
         cfg_valid = poke && (in_n < frame - 1);
         if (cfg_valid) begin
            cfg_cin = 12'd200; cfg_fill_len = '0; cfg_frame_len = CNT_W'(3);
            if (cfg_ready) pv++;
         end
         @(posedge clk); #1;
         k++;
      end
      cfg_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      foreach (got[i]) if (got[i] != i) e++;
      chk("frame_timeout", int'(k < 4000), 1);
      chk("frame_done_pulses", done_n, 1);
      chk("m_beats", got.size(), frame);
      chk("order_errors", e, 0);
      chk("protocol_viol", viol - v0, 0);
      chk("dl_rst_cycles", rst_cnt, 1);
      chk("flush_beats", flush_n, fill);
      chk("input_beats", in_n, frame);
      chk("busy_idle", int'(busy), 0);
      if (poke) begin
         chk("cfg_ready_busy", pv, 0);
         chk("depth_kept", int'(dl_depth), d0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      automatic int k;
      automatic int cin, fill, frame, d;
      automatic bit ok;
      vt = '{'{20, 2, 6, 1'b1, 3}, '{0, 1, 4, 1'b0, 3}, '{1032, 1, 4, 1'b0, 3},
             '{1024, 0, 5, 1'b1, 128}, '{9, 3, 3, 1'b0, 128}, '{9, 0, 0, 1'b0, 128},
             '{4095, 5, 20, 1'b0, 128}, '{1, 2, 3, 1'b1, 1}, '{8, 7, 8, 1'b1, 1},
             '{1025, 0, 2, 1'b0, 1}, '{1017, 3, 4, 1'b1, 128}};
      #12;
      chk_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("busy_after_reset", int'(busy), 0);
      exp_depth = 8;
      apply_cfg(64, 4, 10, 1'b1, 8);
      run_frame(10, 4, 0, 1'b0);
      chk("first_m_valid_cycle", first_mv, 7);
      chk("frame_done_cycle", done_cyc, 17);
      apply_cfg(64, 0, 5, 1'b1, 8);
      run_frame(5, 0, 0, 1'b0);
      chk("fill0_first_m_valid", first_mv, 3);
      chk("fill0_done_cycle", done_cyc, 8);
      exp_depth = 4;
      apply_cfg(32, 2, 8, 1'b1, 4);
      run_frame(8, 2, 2, 1'b0);
      exp_depth = 2;
      apply_cfg(16, 3, 12, 1'b1, 2);
      run_frame(12, 3, 1, 1'b1);
      foreach (vt[i]) begin
         apply_cfg(vt[i].cin, vt[i].fill, vt[i].frame, vt[i].ok, vt[i].depth);
         if (vt[i].ok) run_frame(vt[i].frame, vt[i].fill, 1, 1'b0);
      end
      exp_depth = vt[10].depth;
      for (int r = 0; r < 25; r++) begin
         cin = $urandom_range(0, 1100);
         frame = $urandom_range(0, 30);
         fill = $urandom_range(0, frame + 1);
         d = (cin + 7) / 8;
         ok = d >= 1 && d <= 128 && frame > 0 && fill < frame;
         if (ok) exp_depth = d;
         apply_cfg(cin, fill, frame, ok, exp_depth);
         if (ok) run_frame(frame, fill, 1, 1'b0);
      end
      apply_cfg(64, 4, 10, 1'b1, 8);
      s_valid = 1'b1; m_ready = 1'b1;
      k = 0;
      while (!dl_flush && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach_drain", int'(dl_flush), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      s_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("busy_after_mid_reset", int'(busy), 0);
      chk("no_done_after_reset", int'(frame_done), 0);
      exp_depth = 3;
      apply_cfg(20, 3, 9, 1'b1, 3);
      run_frame(9, 3, 1, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
